// File: rtl/ten_bit_serial_adder.sv
// Bit-serial WIDTH-bit adder S = A + B + Ci, one bit per clock, LSB first; latency WIDTH+1 cycles start->done.
// start is accepted in IDLE or DONE and ignored while busy (no queuing); S/Co hold until the next completion.
module ten_bit_serial_adder #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] r;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             sum_bit;
    logic             carry_nxt;

    assign accept    = start && (state != RUN);
    assign last      = (cnt == CW'(WIDTH - 1));
    assign sum_bit   = op_a[0] ^ op_b[0] ^ c;
    assign carry_nxt = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            r    <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            S    <= '0;
            Co   <= 1'b0;
        end else if (accept) begin
            op_a <= A;
            op_b <= B;
            r    <= '0;
            c    <= Ci;
            cnt  <= '0;
        end else if (state == RUN) begin
            op_a <= {1'b0, op_a[WIDTH-1:1]};
            op_b <= {1'b0, op_b[WIDTH-1:1]};
            r    <= {sum_bit, r[WIDTH-1:1]};
            c    <= carry_nxt;
            cnt  <= cnt + CW'(1);
            // The final bit bypasses r so S is complete on the RUN->DONE edge.
            if (last) begin
                S  <= {sum_bit, r[WIDTH-1:1]};
                Co <= carry_nxt;
            end
        end
    end
endmodule

// File: tb/tb_ten_bit_serial_adder.sv
// Directed bench for ten_bit_serial_adder: reset, add, wrap, subtract, handshake and mid-run reset.
module tb_ten_bit_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] A = '0;
    logic [9:0] B = '0;
    logic       Ci = 1'b0;
    logic       busy;
    logic       done;
    logic [9:0] S;
    logic       Co;

    int vectors = 0;
    int miscompares = 0;

    ten_bit_serial_adder #(.WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Ci(Ci),
        .busy(busy), .done(done), .S(S), .Co(Co)
    );

    always #5 clk = ~clk;

    // Drives start for exactly one rising edge; returns in the first cycle after acceptance.
    task automatic launch(input logic [9:0] a, input logic [9:0] b, input logic ci);
        A = a; B = b; Ci = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, S, Co} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%0b done=%0b S=%0d Co=%0b, want all 0", busy, done, S, Co);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, S, Co} !== 13'b0) begin
                miscompares++;
                $display("FAIL idle_after_reset cyc%0d: busy=%0b done=%0b S=%0d Co=%0b, want all 0",
                         i, busy, done, S, Co);
            end
        end
    endtask

    task automatic test_basic_add();
        launch(10'd5, 10'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_busy cyc%0d: busy=%0b done=%0b, want busy=1 done=0", i + 1, busy, done);
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || S !== 10'd8 || Co !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: done=%0b busy=%0b S=%0d Co=%0b, want done=1 busy=0 S=8 Co=0",
                     done, busy, S, Co);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || S !== 10'd8) begin
            miscompares++;
            $display("FAIL basic_after: done=%0b busy=%0b S=%0d, want done=0 busy=0 S=8", done, busy, S);
        end
    endtask

    task automatic test_wrap();
        launch(10'd1023, 10'd1, 1'b0);
        repeat (10) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || S !== 10'd0 || Co !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_1023p1: done=%0b S=%0d Co=%0b, want done=1 S=0 Co=1", done, S, Co);
        end
        @(negedge clk);
        launch(10'd600, 10'd500, 1'b0);
        repeat (10) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || S !== 10'd76 || Co !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_600p500: done=%0b S=%0d Co=%0b, want done=1 S=76 Co=1", done, S, Co);
        end
        @(negedge clk);
    endtask

    task automatic test_subtract();
        launch(10'd100, 10'd993, 1'b1);
        repeat (10) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || S !== 10'd70 || Co !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_100m30: done=%0b S=%0d Co=%0b, want done=1 S=70 Co=1", done, S, Co);
        end
        @(negedge clk);
        launch(10'd30, 10'd923, 1'b1);
        repeat (10) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || S !== 10'd954 || Co !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_30m100: done=%0b S=%0d Co=%0b, want done=1 S=954 Co=0", done, S, Co);
        end
        @(negedge clk);
    endtask

    // start held high through RUN and DONE; operands change after the accepting edge.
    task automatic test_back_to_back();
        logic [9:0] s_prev;
        s_prev = S;
        A = 10'd100; B = 10'd993; Ci = 1'b1; start = 1'b1;
        @(negedge clk);
        A = 10'd30; B = 10'd923;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1 || S !== s_prev) begin
                miscompares++;
                $display("FAIL b2b_run1 cyc%0d: busy=%0b S=%0d, want busy=1 S=%0d", i + 2, busy, S, s_prev);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || S !== 10'd70 || Co !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: done=%0b S=%0d Co=%0b, want done=1 S=70 Co=1", done, S, Co);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || S !== 10'd70 || Co !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_run2 cyc%0d: busy=%0b done=%0b S=%0d Co=%0b, want busy=1 done=0 S=70 Co=1",
                         i + 1, busy, done, S, Co);
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || S !== 10'd954 || Co !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: done=%0b S=%0d Co=%0b, want done=1 S=954 Co=0", done, S, Co);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        launch(10'd5, 10'd3, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, S, Co} !== 13'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: busy=%0b done=%0b S=%0d Co=%0b, want all 0", busy, done, S, Co);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || S !== 10'd0) begin
                miscompares++;
                $display("FAIL midrun_no_done cyc%0d: done=%0b busy=%0b S=%0d, want 0 0 0", i, done, busy, S);
            end
        end
        launch(10'd7, 10'd9, 1'b0);
        repeat (10) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || S !== 10'd16 || Co !== 1'b0) begin
            miscompares++;
            $display("FAIL fresh_7p9: done=%0b S=%0d Co=%0b, want done=1 S=16 Co=0", done, S, Co);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_wrap();
        test_subtract();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
